// File: rtl/ntt_sequencer.sv
// ntt_sequencer: 7-layer in-place NTT/INTT sequencer for a 12-bit butterfly (q = 3329, n = 256)
// Define NTT_SEQ_PERF_EN to add the perf_cycles busy-cycle counter output.
module ntt_sequencer #(
    parameter int BF_LAT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        inv,
    output logic        busy,
    output logic        done,
    output logic [7:0]  ram_ra_a,
    output logic [7:0]  ram_ra_b,
    output logic        ram_re,
    input  logic [11:0] ram_rd_a,
    input  logic [11:0] ram_rd_b,
    output logic [6:0]  rom_ra,
    input  logic [11:0] rom_rd,
    output logic [11:0] bf_a,
    output logic [11:0] bf_b,
    output logic [11:0] bf_w,
    output logic        bf_ct,
    input  logic [11:0] bf_e,
    input  logic [11:0] bf_o,
    output logic [7:0]  ram_wa_a,
    output logic [7:0]  ram_wa_b,
    output logic [11:0] ram_wd_a,
    output logic [11:0] ram_wd_b,
    output logic        ram_we
`ifdef NTT_SEQ_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);
    localparam int WR_LAT = BF_LAT + 2;
    localparam int DW = $clog2(WR_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                   state_q;
    logic [2:0]               layer_q;
    logic [6:0]               idx_q;
    logic [DW-1:0]            drain_q;
    logic                     ct_q;
    logic                     busy_q;
    logic                     done_q;
    logic [WR_LAT-1:0][16:0]  wb_q;
    logic [16:0]              wb_d;
    logic                     issue;
    logic [3:0]               sh;
    logic [7:0]               len;
    logic [7:0]               grp;
    logic [7:0]               ja;
    logic [6:0]               tw;

    assign issue = state_q == ISSUE;

    // Address and twiddle generation; forward shrinks len per layer, inverse grows it
    always_comb begin
        sh  = ct_q ? 4'd7 - {1'b0, layer_q} : {1'b0, layer_q} + 4'd1;
        len = 8'd1 << sh;
        grp = {1'b0, idx_q} >> sh;
        ja  = (grp << (sh + 4'd1)) | ({1'b0, idx_q} & (len - 8'd1));
        tw  = 7'(ct_q ? (8'd1 << layer_q) + grp : (8'd128 >> layer_q) - 8'd1 - grp);
    end

    assign ram_re   = issue;
    assign ram_ra_a = issue ? ja : '0;
    assign ram_ra_b = issue ? ja + len : '0;
    assign rom_ra   = issue ? tw : '0;
    assign bf_ct    = ct_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_wd_a = bf_e;
    assign ram_wd_b = bf_o;

    // Sequencer: one butterfly per ISSUE cycle, WR_LAT-cycle drain between layers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            layer_q <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            ct_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ct_q    <= ~inv;
                        layer_q <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    idx_q   <= idx_q + 7'd1;
                    drain_q <= '0;
                    if (idx_q == 7'd127)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    drain_q <= drain_q + DW'(1);
                    if (drain_q == DW'(WR_LAT - 1)) begin
                        if (layer_q != 3'd6) begin
                            layer_q <= layer_q + 3'd1;
                            state_q <= ISSUE;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand stage: RAM/ROM data registered into the butterfly inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bf_a <= '0;
            bf_b <= '0;
            bf_w <= '0;
        end else begin
            bf_a <= ram_rd_a;
            bf_b <= ram_rd_b;
            bf_w <= rom_rd;
        end
    end

    assign wb_d = {issue, ram_ra_a, ram_ra_b};

    // Writeback delay line carrying {valid, a_addr, b_addr} to match butterfly latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wb_q <= '0;
        else
            wb_q <= {wb_q[WR_LAT-2:0], wb_d};
    end

    assign {ram_we, ram_wa_a, ram_wa_b} = wb_q[WR_LAT-1];

`ifdef NTT_SEQ_PERF_EN
    logic [15:0] perf_q;

    // Busy-cycle counter, cleared when a start is accepted and held after done
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_q <= '0;
        else if (state_q == IDLE && start)
            perf_q <= '0;
        else if (busy_q)
            perf_q <= perf_q + 16'd1;
    end

    assign perf_cycles = perf_q;
`endif
endmodule
